// File: rtl/ex_sequencer.sv
// ex_sequencer: execute-step controller for an SM83-style core.
// Walks the decoder-supplied step vector one step per machine cycle.
// Supports memory wait-state stalls, early exit on a failed condition,
// and a HALT state that an interrupt wakes.
module ex_sequencer #(
    parameter int MAX_STEPS = 6,
    parameter int STEP_W    = 4,
    parameter int IDLE_CODE = 0,
    parameter int HALT_CODE = 15,
    parameter int IDX_W     = $clog2(MAX_STEPS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_STEPS*STEP_W-1:0] seq_steps,
    input  logic [IDX_W-1:0]            seq_last,
    input  logic                        cond_en,
    input  logic [IDX_W-1:0]            cond_idx,
    input  logic                        cond_taken,
    input  logic                        stall,
    input  logic                        wake,
    output logic [STEP_W-1:0]           step,
    output logic [IDX_W-1:0]            step_idx,
    output logic                        step_valid,
    output logic                        last,
    output logic                        fetch,
    output logic                        retire,
    output logic                        halted
);

    typedef enum logic [1:0] {
        ST_RESUME = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // The index register can address every power-of-two slot; slots past
    // MAX_STEPS read as IDLE so an out-of-range index can never select junk.
    localparam int                N_SLOTS   = 1 << IDX_W;
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(MAX_STEPS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [STEP_W-1:0] IDLE_STEP = STEP_W'(IDLE_CODE);
    localparam logic [STEP_W-1:0] HALT_STEP = STEP_W'(HALT_CODE);

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;

    logic [STEP_W-1:0] step_slot [N_SLOTS];
    logic [STEP_W-1:0] step_cur;
    logic              valid_cur;
    logic              last_cur;
    logic              fetch_cur;
    logic              retire_cur;

    // Unpack the flat step vector into one entry per index.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            if (gi < MAX_STEPS) begin : g_used
                assign step_slot[gi] = seq_steps[gi*STEP_W +: STEP_W];
            end else begin : g_pad
                assign step_slot[gi] = IDLE_STEP;
            end
        end
    endgenerate

    // State and step index; reset drops straight back to a fetch cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RESUME;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state, index advance and the per-cycle step outputs.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        step_cur   = IDLE_STEP;
        valid_cur  = 1'b0;
        last_cur   = 1'b0;
        fetch_cur  = 1'b0;
        retire_cur = 1'b0;
        case (state_reg)
            ST_RESUME: begin
                fetch_cur = !stall;
                if (!stall) begin
                    state_next = ST_RUN;
                    idx_next   = '0;
                end
            end
            ST_RUN: begin
                step_cur  = step_slot[idx_reg];
                valid_cur = !stall;
                // Final step: reached seq_last, hit the hard clamp, or the
                // tested condition failed at its sampling step.
                last_cur  = (idx_reg >= seq_last) ||
                            (idx_reg == IDX_MAX) ||
                            (cond_en && (idx_reg == cond_idx) && !cond_taken);
                fetch_cur  = last_cur && !stall && (step_cur != HALT_STEP);
                retire_cur = last_cur && !stall;
                if (!stall) begin
                    if (step_cur == HALT_STEP) begin
                        // Any remaining steps are abandoned on HALT.
                        state_next = ST_HALT;
                        idx_next   = '0;
                    end else if (last_cur) begin
                        idx_next = '0;
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                    end
                end
            end
            ST_HALT: begin
                // Memory stalls are irrelevant here; only an interrupt counts.
                if (wake) begin
                    state_next = ST_RESUME;
                end
            end
            default: begin
                state_next = ST_RESUME;
                idx_next   = '0;
            end
        endcase
    end

    // Strobes are forced low while reset is held, independent of the clock.
    assign step       = step_cur;
    assign step_idx   = idx_reg;
    assign last       = last_cur;
    assign step_valid = valid_cur  && !rst;
    assign fetch      = fetch_cur  && !rst;
    assign retire     = retire_cur && !rst;
    assign halted     = (state_reg == ST_HALT) && !rst;

endmodule

// File: tb/tb_ex_sequencer.sv
// Directed testbench for ex_sequencer (MAX_STEPS=6, STEP_W=4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
// Observed tuple: {step[3:0], step_idx[2:0], step_valid, last, fetch, retire, halted}.
module tb_ex_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] seq_steps = 24'h654321;
    logic [2:0]  seq_last = 3'd0;
    logic        cond_en = 1'b0;
    logic [2:0]  cond_idx = 3'd1;
    logic        cond_taken = 1'b0;
    logic        stall = 1'b0;
    logic        wake = 1'b0;
    logic [3:0]  step;
    logic [2:0]  step_idx;
    logic        step_valid;
    logic        last;
    logic        fetch;
    logic        retire;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    ex_sequencer #(
        .MAX_STEPS(6),
        .STEP_W(4),
        .IDLE_CODE(0),
        .HALT_CODE(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seq_steps(seq_steps),
        .seq_last(seq_last),
        .cond_en(cond_en),
        .cond_idx(cond_idx),
        .cond_taken(cond_taken),
        .stall(stall),
        .wake(wake),
        .step(step),
        .step_idx(step_idx),
        .step_valid(step_valid),
        .last(last),
        .fetch(fetch),
        .retire(retire),
        .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [11:0] ex(int s, int i, int v, int l, int f, int r, int h);
        return {4'(s), 3'(i), 1'(v), 1'(l), 1'(f), 1'(r), 1'(h)};
    endfunction

    function automatic logic [11:0] obs();
        return {step, step_idx, step_valid, last, fetch, retire, halted};
    endfunction

    task automatic show(string name, int c);
        $display("%s c%0d: step=%0d idx=%0d valid=%0b last=%0b fetch=%0b retire=%0b halted=%0b",
                 name, c, step, step_idx, step_valid, last, fetch, retire, halted);
    endtask

    // Called at a falling edge; leaves the DUT in RESUME with idle inputs.
    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; wake = 1'b0; cond_taken = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] o;
        seq_last = 3'd0; cond_en = 1'b0;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,0,0,0)) begin
            n_err++; $display("FAIL reset_hold got %h want %h", o, ex(0,0,0,0,0,0,0));
        end
        show("reset_hold", 0);
        @(negedge clk);
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,0,0,0)) begin
            n_err++; $display("FAIL reset_hold2 got %h want %h", o, ex(0,0,0,0,0,0,0));
        end
        show("reset_hold", 1);
        rst = 1'b0;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,1,0,0)) begin
            n_err++; $display("FAIL reset_resume got %h want %h", o, ex(0,0,0,0,1,0,0));
        end
        show("reset_resume", 0);
        @(negedge clk);
        // One-step instructions: fetch and retire every cycle, idx stays 0.
        for (int c = 0; c < 3; c++) begin
            #1;
            o = obs(); n_vec++;
            if (o !== ex(1,0,1,1,1,1,0)) begin
                n_err++; $display("FAIL one_step c%0d got %h want %h", c, o, ex(1,0,1,1,1,1,0));
            end
            show("one_step", c);
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [2:0]  stim [8];
        logic [11:0] expv [8];
        logic [11:0] o;
        stim = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        expv = '{ex(0,0,0,0,1,0,0), ex(1,0,1,0,0,0,0), ex(2,1,1,0,0,0,0),
                 ex(3,2,0,0,0,0,0), ex(3,2,0,0,0,0,0), ex(3,2,1,0,0,0,0),
                 ex(4,3,1,1,1,1,0), ex(1,0,1,0,0,0,0)};
        seq_steps = 24'h654321; seq_last = 3'd3; cond_en = 1'b0; cond_idx = 3'd1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            {stall, wake, cond_taken} = stim[c];
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL stall c%0d got %h want %h", c, o, expv[c]);
            end
            show("stall", c);
            @(negedge clk);
        end
    endtask

    task automatic test_cond();
        logic [2:0]  stim [10];
        logic [11:0] expv [10];
        logic [11:0] o;
        stim = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        expv = '{ex(0,0,0,0,1,0,0), ex(1,0,1,0,0,0,0), ex(2,1,1,1,1,1,0),
                 ex(1,0,1,0,0,0,0), ex(2,1,0,1,0,0,0), ex(2,1,1,0,0,0,0),
                 ex(3,2,1,0,0,0,0), ex(4,3,1,0,0,0,0), ex(5,4,1,1,1,1,0),
                 ex(1,0,1,0,0,0,0)};
        seq_steps = 24'h654321; seq_last = 3'd4; cond_en = 1'b1; cond_idx = 3'd1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            {stall, wake, cond_taken} = stim[c];
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL cond c%0d got %h want %h", c, o, expv[c]);
            end
            show("cond", c);
            @(negedge clk);
        end
        cond_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [11:0] expv [4];
        logic [11:0] o;
        expv = '{ex(0,0,0,0,1,0,0), ex(1,0,1,0,0,0,0), ex(2,1,1,1,1,1,0),
                 ex(1,0,1,0,0,0,0)};
        seq_steps = 24'h654321; seq_last = 3'd1; cond_en = 1'b1; cond_idx = 3'd1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL simult c%0d got %h want %h", c, o, expv[c]);
            end
            show("simult", c);
            @(negedge clk);
        end
        cond_en = 1'b0;
    endtask

    task automatic test_clamp();
        logic [11:0] expv [8];
        logic [11:0] o;
        expv = '{ex(0,0,0,0,1,0,0), ex(1,0,1,0,0,0,0), ex(2,1,1,0,0,0,0),
                 ex(3,2,1,0,0,0,0), ex(4,3,1,0,0,0,0), ex(5,4,1,0,0,0,0),
                 ex(6,5,1,1,1,1,0), ex(1,0,1,0,0,0,0)};
        seq_steps = 24'h654321; seq_last = 3'd7; cond_en = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL clamp c%0d got %h want %h", c, o, expv[c]);
            end
            show("clamp", c);
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [2:0]  stim [16];
        logic [11:0] expv [16];
        logic [11:0] o;
        stim[0] = 3'b000; expv[0] = ex(0,0,0,0,1,0,0);
        stim[1] = 3'b000; expv[1] = ex(0,0,1,0,0,0,0);
        stim[2] = 3'b000; expv[2] = ex(15,1,1,1,0,1,0);
        for (int c = 3; c < 13; c++) begin
            stim[c] = (c % 2 == 0) ? 3'b100 : 3'b000;
            expv[c] = ex(0,0,0,0,0,0,1);
        end
        stim[13] = 3'b010; expv[13] = ex(0,0,0,0,0,0,1);
        stim[14] = 3'b000; expv[14] = ex(0,0,0,0,1,0,0);
        stim[15] = 3'b000; expv[15] = ex(0,0,1,0,0,0,0);
        seq_steps = 24'h6543F0; seq_last = 3'd1; cond_en = 1'b0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            {stall, wake, cond_taken} = stim[c];
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL halt c%0d got %h want %h", c, o, expv[c]);
            end
            show("halt", c);
            @(negedge clk);
        end
    endtask

    task automatic test_halt_early();
        logic [2:0]  stim [7];
        logic [11:0] expv [7];
        logic [11:0] o;
        stim = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b000};
        expv = '{ex(0,0,0,0,1,0,0), ex(0,0,1,0,0,0,0), ex(15,1,0,0,0,0,0),
                 ex(15,1,1,0,0,0,0), ex(0,0,0,0,0,0,1), ex(0,0,0,0,1,0,0),
                 ex(0,0,1,0,0,0,0)};
        seq_steps = 24'h6543F0; seq_last = 3'd3; cond_en = 1'b0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            {stall, wake, cond_taken} = stim[c];
            #1;
            o = obs(); n_vec++;
            if (o !== expv[c]) begin
                n_err++; $display("FAIL halt_early c%0d got %h want %h", c, o, expv[c]);
            end
            show("halt_early", c);
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] o;
        // Abort a 4-step instruction while at idx 2.
        seq_steps = 24'h654321; seq_last = 3'd3; cond_en = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        o = obs(); n_vec++;
        if (o !== ex(3,2,1,0,0,0,0)) begin
            n_err++; $display("FAIL arst_pre got %h want %h", o, ex(3,2,1,0,0,0,0));
        end
        show("arst_pre", 0);
        rst = 1'b1;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,0,0,0)) begin
            n_err++; $display("FAIL arst_run got %h want %h", o, ex(0,0,0,0,0,0,0));
        end
        show("arst_run", 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,1,0,0)) begin
            n_err++; $display("FAIL arst_resume got %h want %h", o, ex(0,0,0,0,1,0,0));
        end
        show("arst_resume", 0);
        @(negedge clk);
        #1;
        o = obs(); n_vec++;
        if (o !== ex(1,0,1,0,0,0,0)) begin
            n_err++; $display("FAIL arst_idx0 got %h want %h", o, ex(1,0,1,0,0,0,0));
        end
        show("arst_idx0", 0);
        @(negedge clk);

        // Abort a HALT.
        seq_steps = 24'h6543F0; seq_last = 3'd1;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,0,0,1)) begin
            n_err++; $display("FAIL arst_inhalt got %h want %h", o, ex(0,0,0,0,0,0,1));
        end
        show("arst_inhalt", 0);
        rst = 1'b1;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,0,0,0)) begin
            n_err++; $display("FAIL arst_halt got %h want %h", o, ex(0,0,0,0,0,0,0));
        end
        show("arst_halt", 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,0,0,1,0,0)) begin
            n_err++; $display("FAIL arst_halt_resume got %h want %h", o, ex(0,0,0,0,1,0,0));
        end
        show("arst_halt_resume", 0);
        @(negedge clk);
        #1;
        o = obs(); n_vec++;
        if (o !== ex(0,0,1,0,0,0,0)) begin
            n_err++; $display("FAIL arst_halt_idx0 got %h want %h", o, ex(0,0,1,0,0,0,0));
        end
        show("arst_halt_idx0", 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_cond();
        test_simultaneous();
        test_clamp();
        test_halt();
        test_halt_early();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
